// File: rtl/riscv_regmask_lsu_sequencer.sv
// Register-list load/store-multiple sequencer: walks a 32-bit register mask and
// issues one pipelined word access per set bit on the OBI data port.
`timescale 1ns/1ps
module riscv_regmask_lsu_sequencer #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_STEP       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        is_load_i,
  input  logic        descending_i,
  input  logic [31:0] reg_mask_i,
  input  logic [31:0] base_addr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] final_addr_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [31:0] data_rdata_i,
  output logic [4:0]  rf_raddr_o,
  input  logic [31:0] rf_rdata_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
  localparam logic [31:0]   STEP     = 32'(ADDR_STEP);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state_q;
  logic [31:0]   mask_q;
  logic [31:0]   addr_q;
  logic          desc_q;
  logic          we_q;
  logic          err_q;
  logic          pend_q;
  logic [CW-1:0] out_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [4:0]    tag_q [MAX_OUTSTANDING];

  logic [4:0]    cur_reg;
  logic [31:0]   cur_bit;
  logic          rsp;
  logic          rsp_err;
  logic          grant;
  logic [31:0]   mask_d;
  logic [CW-1:0] out_d;

  // Next register: lowest set bit ascending, highest set bit descending.
  always_comb begin
    cur_reg = '0;
    if (desc_q) begin
      for (int i = 1; i < 32; i++)
        if (mask_q[i]) cur_reg = 5'(i);
    end else begin
      for (int i = 31; i > 0; i--)
        if (mask_q[i]) cur_reg = 5'(i);
    end
  end

  assign cur_bit    = 32'd1 << cur_reg;
  assign rsp        = data_rvalid_i && (state_q != IDLE) && (out_q != '0);
  assign rsp_err    = rsp && data_err_i;
  assign data_req_o = (state_q == ISSUE) && (mask_q != '0) &&
                      (pend_q || (out_q < MAX_CNT) || rsp);
  assign grant      = data_req_o && data_gnt_i;

  // On error only an already-raised, ungranted request survives in the mask.
  always_comb begin
    mask_d = mask_q;
    if (grant) mask_d = mask_q & ~cur_bit;
    if (rsp_err) mask_d = (data_req_o && !data_gnt_i) ? cur_bit : '0;
  end

  always_comb begin
    out_d = out_q;
    if (grant && !rsp) out_d = out_q + CW'(1);
    else if (!grant && rsp) out_d = out_q - CW'(1);
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign err_o        = done_o && err_q;
  assign final_addr_o = done_o ? addr_q : '0;
  assign data_addr_o  = addr_q;
  assign data_we_o    = we_q;
  assign data_be_o    = data_req_o ? 4'hF : 4'h0;
  assign data_wdata_o = rf_rdata_i;
  assign rf_raddr_o   = cur_reg;
  assign rf_we_o      = rsp && !we_q && !data_err_i && !err_q;
  assign rf_waddr_o   = tag_q[rd_ptr_q];
  assign rf_wdata_o   = data_rdata_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      addr_q   <= '0;
      desc_q   <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      out_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_q[i] <= '0;
    end else begin
      pend_q <= data_req_o && !data_gnt_i;
      out_q  <= out_d;
      if (grant) begin
        tag_q[wr_ptr_q] <= cur_reg;
        wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        addr_q          <= desc_q ? addr_q - STEP : addr_q + STEP;
      end
      if (rsp) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
      if (rsp_err) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mask_q  <= reg_mask_i & 32'hFFFF_FFFE;
            addr_q  <= base_addr_i;
            desc_q  <= descending_i;
            we_q    <= !is_load_i;
            err_q   <= 1'b0;
            state_q <= ((reg_mask_i & 32'hFFFF_FFFE) != '0) ? ISSUE : DONE;
          end
        end
        ISSUE: begin
          mask_q <= mask_d;
          if (mask_d == '0) state_q <= (out_d == '0) ? DONE : DRAIN;
        end
        DRAIN: begin
          mask_q <= '0;
          if (out_d == '0) state_q <= DONE;
        end
        DONE: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
    (data_rvalid_i && state_q != IDLE) |-> (out_q != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (grant && !rsp) |-> (out_q < MAX_CNT));

endmodule

// File: tb/tb_riscv_regmask_lsu_sequencer.sv
// Scoreboard bench for riscv_regmask_lsu_sequencer: a bus/regfile model drives
// the DUT and observed accesses and regfile writes are compared to expectations.
`timescale 1ns/1ps
module tb_riscv_regmask_lsu_sequencer;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0, is_load_i = 1'b0, descending_i = 1'b0;
  logic [31:0] reg_mask_i = '0, base_addr_i = '0;
  logic        busy_o, done_o, err_o;
  logic [31:0] final_addr_o;
  logic        data_req_o, data_we_o;
  logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0, data_err_i = 1'b0;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i = '0;
  logic [3:0]  data_be_o;
  logic [4:0]  rf_raddr_o, rf_waddr_o;
  logic [31:0] rf_rdata_i, rf_wdata_o;
  logic        rf_we_o;

  riscv_regmask_lsu_sequencer #(.MAX_OUTSTANDING(MAXO), .ADDR_STEP(4)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .is_load_i(is_load_i),
    .descending_i(descending_i), .reg_mask_i(reg_mask_i), .base_addr_i(base_addr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .final_addr_o(final_addr_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .data_rdata_i(data_rdata_i),
    .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i), .rf_we_o(rf_we_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
  );

  always #5 clk = ~clk;

  logic [31:0] rf_model [32];
  assign rf_rdata_i = rf_model[rf_raddr_o];

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [4:0]  reg_idx;
  } acc_t;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rfw_t;

  acc_t exp_acc_q[$], obs_acc_q[$];
  rfw_t exp_rf_q[$], obs_rf_q[$];

  int checks = 0;
  int errors = 0;
  int done_cycle, last_rvalid_cycle, stable_viol, max_out;
  logic [31:0] obs_final;
  logic        obs_err;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_F00D;
  endfunction

  // Builds the expected access/regfile-write order; returns the expected final address.
  function automatic logic [31:0] build_expected(input logic load, input logic desc,
                                                 input logic [31:0] mask,
                                                 input logic [31:0] base, input int limit);
    logic [31:0] a = base;
    int n = 0;
    exp_acc_q.delete();
    exp_rf_q.delete();
    for (int k = 1; k < 32; k++) begin
      int r = desc ? 32 - k : k;
      if (mask[r] && n < limit) begin
        acc_t e;
        rfw_t w;
        e.addr = a; e.we = !load; e.wdata = rf_model[r]; e.reg_idx = 5'(r);
        exp_acc_q.push_back(e);
        if (load) begin
          w.waddr = 5'(r); w.wdata = mem_data(a);
          exp_rf_q.push_back(w);
        end
        a = desc ? a - 32'd4 : a + 32'd4;
        n++;
      end
    end
    return a;
  endfunction

  // Drives one sequence through a bus model with configurable grant/response delay.
  task automatic run_seq(input logic load, input logic desc, input logic [31:0] mask,
                         input logic [31:0] base, input int gnt_delay, input int rsp_delay,
                         input int err_idx, input int abort_grants, input int restart_cycle);
    int          ready_q[$];
    logic [31:0] raddr_q[$];
    int          resp_idx = 0, req_wait = 0, outst = 0, grants = 0;
    logic        prev_req = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    bit          fin = 1'b0;
    obs_acc_q.delete();
    obs_rf_q.delete();
    done_cycle = -1; last_rvalid_cycle = -100; stable_viol = 0; max_out = 0;
    obs_final = 'x; obs_err = 'x;
    @(posedge clk); #1;
    start_i = 1'b1; is_load_i = load; descending_i = desc;
    reg_mask_i = mask; base_addr_i = base;
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(posedge clk); #1;
      start_i = (cyc == restart_cycle);
      if (cyc == restart_cycle) reg_mask_i = 32'hFFFF_FFFE;
      data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
      if (ready_q.size() > 0 && ready_q[0] <= cyc) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = mem_data(raddr_q[0]);
        data_err_i    = (resp_idx == err_idx);
        void'(ready_q.pop_front());
        void'(raddr_q.pop_front());
        resp_idx++;
        outst--;
        last_rvalid_cycle = cyc;
      end
      #1;
      data_gnt_i = 1'b0;
      if (data_req_o) begin
        if (prev_req && (data_addr_o !== prev_addr || data_we_o !== prev_we ||
                         data_wdata_o !== prev_wdata)) stable_viol++;
        req_wait++;
        if (req_wait > gnt_delay) begin
          data_gnt_i = 1'b1;
          req_wait = 0;
        end
      end else begin
        if (prev_req) stable_viol++;
        req_wait = 0;
      end
      #1;
      if (data_req_o && data_gnt_i) begin
        acc_t o;
        o.addr = data_addr_o; o.we = data_we_o; o.wdata = data_wdata_o; o.reg_idx = rf_raddr_o;
        obs_acc_q.push_back(o);
        ready_q.push_back(cyc + 1 + rsp_delay);
        raddr_q.push_back(data_addr_o);
        outst++;
        grants++;
        if (outst > max_out) max_out = outst;
      end
      if (rf_we_o) begin
        rfw_t w;
        w.waddr = rf_waddr_o; w.wdata = rf_wdata_o;
        obs_rf_q.push_back(w);
      end
      if (done_o) begin
        done_cycle = cyc; obs_final = final_addr_o; obs_err = err_o;
        fin = 1'b1;
      end
      prev_req = data_req_o && !data_gnt_i;
      prev_addr = data_addr_o; prev_we = data_we_o; prev_wdata = data_wdata_o;
      if (abort_grants > 0 && grants >= abort_grants) fin = 1'b1;
    end
    #1;
    start_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy_o, done_o, err_o, data_req_o, data_we_o, data_be_o, rf_we_o} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 0",
               {busy_o, done_o, err_o, data_req_o, data_we_o, data_be_o, rf_we_o});
    end
    checks++;
    if ({final_addr_o, data_addr_o, rf_raddr_o, rf_waddr_o} !== 74'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: final=%h addr=%h raddr=%0d waddr=%0d, expected all 0",
               final_addr_o, data_addr_o, rf_raddr_o, rf_waddr_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || data_req_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: busy=%b req=%b, expected 0 0", busy_o, data_req_o);
    end
  endtask

  task automatic test_store_ascending();
    logic [31:0] exp_final;
    exp_final = build_expected(1'b0, 1'b0, 32'h0000_0302, 32'h1000, 32);
    run_seq(1'b0, 1'b0, 32'h0000_0302, 32'h1000, 0, 0, -1, 0, -1);
    checks++;
    if (obs_acc_q.size() != exp_acc_q.size()) begin
      errors++;
      $display("[TB] FAIL store_count: got %0d accesses, expected %0d", obs_acc_q.size(), exp_acc_q.size());
    end
    while (obs_acc_q.size() > 0 && exp_acc_q.size() > 0) begin
      acc_t o = obs_acc_q.pop_front();
      acc_t e = exp_acc_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL store_acc: got addr=%h we=%b wdata=%h reg=%0d, expected addr=%h we=%b wdata=%h reg=%0d",
                 o.addr, o.we, o.wdata, o.reg_idx, e.addr, e.we, e.wdata, e.reg_idx);
      end
    end
    checks++;
    if (obs_rf_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL store_rf_we: got %0d regfile writes, expected 0", obs_rf_q.size());
    end
    checks++;
    if (done_cycle != 5) begin
      errors++;
      $display("[TB] FAIL store_latency: done at cycle %0d, expected 5", done_cycle);
    end
    checks++;
    if (obs_final !== exp_final || obs_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL store_final: got final=%h err=%b, expected final=%h err=0", obs_final, obs_err, exp_final);
    end
  endtask

  task automatic test_load_descending();
    logic [31:0] exp_final;
    exp_final = build_expected(1'b1, 1'b1, 32'h000C_0002, 32'h2010, 32);
    run_seq(1'b1, 1'b1, 32'h000C_0002, 32'h2010, 0, 0, -1, 0, -1);
    checks++;
    if (obs_acc_q.size() != 3) begin
      errors++;
      $display("[TB] FAIL load_count: got %0d accesses, expected 3", obs_acc_q.size());
    end
    while (obs_acc_q.size() > 0 && exp_acc_q.size() > 0) begin
      acc_t o = obs_acc_q.pop_front();
      acc_t e = exp_acc_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL load_acc: got addr=%h we=%b reg=%0d, expected addr=%h we=%b reg=%0d",
                 o.addr, o.we, o.reg_idx, e.addr, e.we, e.reg_idx);
      end
    end
    checks++;
    if (obs_rf_q.size() != exp_rf_q.size()) begin
      errors++;
      $display("[TB] FAIL load_rf_count: got %0d writes, expected %0d", obs_rf_q.size(), exp_rf_q.size());
    end
    while (obs_rf_q.size() > 0 && exp_rf_q.size() > 0) begin
      rfw_t o = obs_rf_q.pop_front();
      rfw_t e = exp_rf_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL load_rf: got x%0d=%h, expected x%0d=%h", o.waddr, o.wdata, e.waddr, e.wdata);
      end
    end
    checks++;
    if (done_cycle != 5 || done_cycle != last_rvalid_cycle + 1) begin
      errors++;
      $display("[TB] FAIL load_latency: done at %0d (last rvalid %0d), expected 5", done_cycle, last_rvalid_cycle);
    end
    checks++;
    if (obs_final !== 32'h2004 || obs_final !== exp_final || obs_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_final: got final=%h err=%b, expected final=00002004 err=0", obs_final, obs_err);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_final;
    exp_final = build_expected(1'b1, 1'b0, 32'h0000_F0F0, 32'h3000, 32);
    run_seq(1'b1, 1'b0, 32'h0000_F0F0, 32'h3000, 3, 2, -1, 0, -1);
    checks++;
    if (stable_viol != 0) begin
      errors++;
      $display("[TB] FAIL bp_stability: got %0d unstable request cycles, expected 0", stable_viol);
    end
    checks++;
    if (max_out > MAXO || max_out < 1) begin
      errors++;
      $display("[TB] FAIL bp_outstanding: got max %0d, expected 1..%0d", max_out, MAXO);
    end
    checks++;
    if (obs_acc_q.size() != exp_acc_q.size()) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d accesses, expected %0d", obs_acc_q.size(), exp_acc_q.size());
    end
    while (obs_acc_q.size() > 0 && exp_acc_q.size() > 0) begin
      acc_t o = obs_acc_q.pop_front();
      acc_t e = exp_acc_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL bp_acc: got addr=%h reg=%0d, expected addr=%h reg=%0d", o.addr, o.reg_idx, e.addr, e.reg_idx);
      end
    end
    checks++;
    if (obs_rf_q.size() != exp_rf_q.size()) begin
      errors++;
      $display("[TB] FAIL bp_rf_count: got %0d writes, expected %0d", obs_rf_q.size(), exp_rf_q.size());
    end
    while (obs_rf_q.size() > 0 && exp_rf_q.size() > 0) begin
      rfw_t o = obs_rf_q.pop_front();
      rfw_t e = exp_rf_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL bp_rf: got x%0d=%h, expected x%0d=%h", o.waddr, o.wdata, e.waddr, e.wdata);
      end
    end
    checks++;
    if (done_cycle < 0 || done_cycle != last_rvalid_cycle + 1 || obs_final !== exp_final) begin
      errors++;
      $display("[TB] FAIL bp_done: done at %0d final=%h, expected at %0d final=%h",
               done_cycle, obs_final, last_rvalid_cycle + 1, exp_final);
    end
  endtask

  task automatic test_error();
    // The 2nd response errors while the 3rd request waits for its grant: it still
    // completes, the 4th is never issued and only x1 gets written back.
    build_expected(1'b1, 1'b0, 32'h0000_001E, 32'h4000, 3);
    while (exp_rf_q.size() > 1) void'(exp_rf_q.pop_back());
    run_seq(1'b1, 1'b0, 32'h0000_001E, 32'h4000, 1, 0, 1, 0, -1);
    checks++;
    if (obs_acc_q.size() != 3) begin
      errors++;
      $display("[TB] FAIL err_count: got %0d accesses, expected 3", obs_acc_q.size());
    end
    while (obs_acc_q.size() > 0 && exp_acc_q.size() > 0) begin
      acc_t o = obs_acc_q.pop_front();
      acc_t e = exp_acc_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL err_acc: got addr=%h reg=%0d, expected addr=%h reg=%0d", o.addr, o.reg_idx, e.addr, e.reg_idx);
      end
    end
    checks++;
    if (obs_rf_q.size() != 1) begin
      errors++;
      $display("[TB] FAIL err_rf_count: got %0d writes, expected 1", obs_rf_q.size());
    end else if (obs_rf_q[0] !== exp_rf_q[0]) begin
      errors++;
      $display("[TB] FAIL err_rf: got x%0d=%h, expected x%0d=%h",
               obs_rf_q[0].waddr, obs_rf_q[0].wdata, exp_rf_q[0].waddr, exp_rf_q[0].wdata);
    end
    checks++;
    if (stable_viol != 0) begin
      errors++;
      $display("[TB] FAIL err_stability: got %0d unstable request cycles, expected 0", stable_viol);
    end
    checks++;
    if (done_cycle != 8 || obs_err !== 1'b1 || obs_final !== 32'h400C) begin
      errors++;
      $display("[TB] FAIL err_done: done at %0d err=%b final=%h, expected at 8 err=1 final=0000400c",
               done_cycle, obs_err, obs_final);
    end
  endtask

  task automatic test_empty_masks();
    logic [31:0] masks [2];
    logic [31:0] bases [2];
    masks[0] = 32'h0000_0000; bases[0] = 32'h5000;
    masks[1] = 32'h0000_0001; bases[1] = 32'h5444;
    for (int t = 0; t < 2; t++) begin
      run_seq(t[0], 1'b0, masks[t], bases[t], 0, 0, -1, 0, -1);
      checks++;
      if (obs_acc_q.size() != 0) begin
        errors++;
        $display("[TB] FAIL empty_req[%0d]: got %0d accesses, expected 0", t, obs_acc_q.size());
      end
      checks++;
      if (done_cycle != 1 || obs_final !== bases[t] || obs_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL empty_done[%0d]: done at %0d final=%h err=%b, expected at 1 final=%h err=0",
                 t, done_cycle, obs_final, obs_err, bases[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_final;
    // Abort after one grant, then check that reset clears everything.
    run_seq(1'b0, 1'b0, 32'h0000_00FE, 32'h6000, 0, 5, -1, 1, -1);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy_o, done_o, err_o, data_req_o, data_we_o, data_be_o, rf_we_o} !== 10'd0 ||
        data_addr_o !== 32'd0 || final_addr_o !== 32'd0 || rf_raddr_o !== 5'd0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: busy=%b req=%b we=%b addr=%h raddr=%0d, expected all 0",
               busy_o, data_req_o, data_we_o, data_addr_o, rf_raddr_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (rf_we_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL late_rvalid: rf_we=%b busy=%b, expected 0 0", rf_we_o, busy_o);
    end
    @(posedge clk); #1;
    data_rvalid_i = 1'b0; data_rdata_i = '0;
    // Fresh run with a second start pulse while busy, which must be ignored.
    exp_final = build_expected(1'b1, 1'b0, 32'h0000_0002, 32'h7000, 32);
    run_seq(1'b1, 1'b0, 32'h0000_0002, 32'h7000, 0, 0, -1, 0, 1);
    checks++;
    if (obs_acc_q.size() != 1 || exp_acc_q.size() != 1 || obs_acc_q[0] !== exp_acc_q[0]) begin
      errors++;
      $display("[TB] FAIL restart_acc: got %0d accesses, expected 1 to x1 at 00007000", obs_acc_q.size());
    end
    checks++;
    if (obs_rf_q.size() != 1 || obs_rf_q[0] !== exp_rf_q[0]) begin
      errors++;
      $display("[TB] FAIL restart_rf: got %0d writes, expected 1 to x1", obs_rf_q.size());
    end
    checks++;
    if (done_cycle != 3 || obs_final !== exp_final || obs_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_done: done at %0d final=%h err=%b, expected at 3 final=%h err=0",
               done_cycle, obs_final, obs_err, exp_final);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_pulse: busy=%b done=%b after completion, expected 0 0", busy_o, done_o);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      rf_model[i] = (i == 0) ? 32'd0 : (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
    test_reset();
    test_store_ascending();
    test_load_descending();
    test_backpressure();
    test_error();
    test_empty_masks();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
